// File: rtl/ofmap_writeback_if.sv
// PPU-to-DRAM writeback bundle: tile control, the PPU byte stream and the
// word-addressed DRAM write channel, plus status.
interface ofmap_writeback_if #(
    parameter int unsigned ADDR_W = 16
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              ofmap_valid;
    logic [7:0]        ofmap_data;
    logic              dram_wvalid;
    logic [ADDR_W-1:0] dram_waddr;
    logic [31:0]       dram_wdata;
    logic              dram_wready;
    logic              busy;
    logic              tile_done;
    logic              overflow;

    // Writeback engine view.
    modport master (
        input  start, base_addr, ofmap_valid, ofmap_data, dram_wready,
        output dram_wvalid, dram_waddr, dram_wdata, busy, tile_done, overflow
    );

    // Controller / PPU / DRAM view.
    modport slave (
        output start, base_addr, ofmap_valid, ofmap_data, dram_wready,
        input  dram_wvalid, dram_waddr, dram_wdata, busy, tile_done, overflow
    );
endinterface

// File: rtl/ofmap_writeback.sv
// Packs one tile of int8 PPU output into little-endian 32-bit words, buffers
// them in a small FIFO and writes them to contiguous DRAM word addresses.
module ofmap_writeback #(
    parameter int unsigned WIDTH      = 64,
    parameter int unsigned PACK       = 4,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned ADDR_W     = 16
) (
    input logic               clk,
    input logic               rst_n,
    ofmap_writeback_if.master bus
);
    localparam int unsigned NWORDS = WIDTH / PACK;
    localparam int unsigned BCW    = $clog2(WIDTH);
    localparam int unsigned WCW    = $clog2(NWORDS + 1);
    localparam int unsigned PW     = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [BCW-1:0]    byte_cnt_q, byte_cnt_d;
    logic [WCW-1:0]    sent_q, sent_d;
    logic [WCW-1:0]    dropped_q, dropped_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [31:0]       pack_q, pack_d;
    logic [PW:0]       wr_ptr_q, wr_ptr_d;
    logic [PW:0]       rd_ptr_q, rd_ptr_d;
    logic              ovf_q, ovf_d;
    logic [31:0]       mem_q [FIFO_DEPTH];

    logic              active, wvalid, pop, byte_in, push_req, push_ok, drop;
    logic              fifo_empty, fifo_full;
    logic [PW:0]       fifo_cnt;
    logic [1:0]        lane;
    logic [31:0]       word_in;

    assign active     = (state_q == S_COLLECT) || (state_q == S_DRAIN);
    assign fifo_cnt   = wr_ptr_q - rd_ptr_q;
    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == (PW+1)'(FIFO_DEPTH));
    assign wvalid     = active && !fifo_empty;
    assign pop        = wvalid && bus.dram_wready;
    assign byte_in    = (state_q == S_COLLECT) && bus.ofmap_valid;
    assign lane       = byte_cnt_q[1:0];
    assign push_req   = byte_in && (lane == 2'd3);
    // A pop in the same cycle frees a slot, so a full FIFO still takes the word.
    assign push_ok    = push_req && (!fifo_full || pop);
    assign drop       = push_req && fifo_full && !pop;
    assign word_in    = {bus.ofmap_data, pack_q[23:0]};

    assign bus.dram_wvalid = wvalid;
    assign bus.dram_wdata  = wvalid ? mem_q[rd_ptr_q[PW-1:0]] : '0;
    assign bus.dram_waddr  = active ? base_q + ADDR_W'(sent_q) : '0;
    assign bus.busy        = active;
    assign bus.tile_done   = (state_q == S_DONE);
    assign bus.overflow    = ovf_q;

    // Next-state: FSM transitions, byte packing, FIFO pointers and counters.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        sent_d     = sent_q;
        dropped_d  = dropped_q;
        base_d     = base_q;
        pack_d     = pack_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        ovf_d      = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d    = S_COLLECT;
                    base_d     = bus.base_addr;
                    byte_cnt_d = '0;
                    sent_d     = '0;
                    dropped_d  = '0;
                    ovf_d      = 1'b0;
                    pack_d     = '0;
                    wr_ptr_d   = '0;
                    rd_ptr_d   = '0;
                end
            end
            S_COLLECT: begin
                if (byte_in) begin
                    pack_d[{lane, 3'b000} +: 8] = bus.ofmap_data;
                    byte_cnt_d = byte_cnt_q + BCW'(1);
                    if (byte_cnt_q == BCW'(WIDTH - 1)) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Dropped words never reach DRAM, so they count towards completion.
                if ((sent_q + dropped_q) == WCW'(NWORDS)) state_d = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (push_ok) wr_ptr_d = wr_ptr_q + (PW+1)'(1);
        if (pop) begin
            rd_ptr_d = rd_ptr_q + (PW+1)'(1);
            sent_d   = sent_q + WCW'(1);
        end
        if (drop) begin
            dropped_d = dropped_q + WCW'(1);
            ovf_d     = 1'b1;
        end
    end

    // Control and datapath state registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= '0;
            sent_q     <= '0;
            dropped_q  <= '0;
            base_q     <= '0;
            pack_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            sent_q     <= sent_d;
            dropped_q  <= dropped_d;
            base_q     <= base_d;
            pack_q     <= pack_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ovf_q      <= ovf_d;
        end
    end

    // FIFO storage; contents are only observable through valid pointers.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[PW-1:0]] <= word_in;
    end
endmodule

// File: doc/ofmap_writeback.md
Name: ofmap_writeback

Overview:
- Drains one tile of int8 PPU output from the GLB/PPU side back to DRAM.
- During the controller's PPU phase it accepts one byte per cycle with no backpressure.
- It packs every 4 bytes little-endian into a 32-bit word, buffers the words in a small FIFO, and issues word-addressed DRAM writes over a valid/ready handshake.
- It pulses tile_done once every word of the tile has been accepted by DRAM; the top level uses this as the next-tile ready.

Parameters:
- WIDTH, 64, int8 outputs per tile; must be a multiple of PACK.
- PACK, 4, bytes per DRAM word (fixed at 4 for 32-bit data).
- FIFO_DEPTH, 8, packed-word FIFO entries; power of 2.
- ADDR_W, 16, DRAM word-address width.

Ports:
- clk, in, 1: single clock.
- rst_n, in, 1: reset, asynchronous, active-low.
- start, in, 1: one-cycle pulse that begins a tile; honoured only in IDLE.
- base_addr, in, ADDR_W: DRAM word address of word 0; latched on an accepted start.
- ofmap_valid, in, 1: a PPU output byte is present this cycle.
- ofmap_data, in, 8: int8 PPU output byte.
- dram_wvalid, out, 1: write request valid.
- dram_waddr, out, ADDR_W: word address of the current request.
- dram_wdata, out, 32: packed word of the current request.
- dram_wready, in, 1: DRAM accepts the request this cycle.
- busy, out, 1: high in COLLECT or DRAIN.
- tile_done, out, 1: one-cycle pulse when the tile is fully written.
- overflow, out, 1: sticky flag; a packed word was dropped.

Behaviour:
- Reset (rst_n low, asynchronous): FSM goes to IDLE; byte, word and address counters, pack register and FIFO pointers clear. dram_wvalid, busy, tile_done and overflow are 0; dram_waddr and dram_wdata are 0.
- Reset mid-tile aborts the tile: no tile_done, and buffered words are discarded.
- FSM states: IDLE, COLLECT, DRAIN, DONE.
- IDLE:
  - start -> COLLECT. On that edge: latch base_addr, clear byte count, words-sent count and overflow.
  - ofmap_valid is ignored.
- COLLECT:
  - Each cycle with ofmap_valid, shift the byte into the pack register at lane (byte_cnt mod 4). Lane 0 goes to bits [7:0], lane 3 to bits [31:24].
  - Gaps in ofmap_valid are allowed.
  - On the 4th byte, the completed word (including that byte) is pushed to the FIFO on the same edge.
  - When byte WIDTH-1 is accepted -> DRAIN.
- DRAIN:
  - ofmap_valid is ignored.
  - When words_sent reaches WIDTH/PACK -> DONE.
- DONE: tile_done = 1 for exactly one cycle, then -> IDLE. busy = 0.
- start outside IDLE is ignored.
- DRAM side, active in COLLECT and DRAIN:
  - dram_wvalid = FIFO non-empty.
  - dram_wdata = FIFO head (show-ahead).
  - dram_waddr = base + words_sent, truncated to ADDR_W (wraps modulo 2^ADDR_W).
  - Pop and increment words_sent on dram_wvalid && dram_wready.
  - dram_wdata and dram_waddr must hold stable while dram_wvalid is high and dram_wready is low.
- Latency: 4th byte of a word sampled at edge t -> dram_wvalid high from t+1. The minimum tile time with dram_wready=1 is WIDTH cycles plus 2 cycles to tile_done.
- FIFO boundaries:
  - A push is accepted if the FIFO is not full, or a pop occurs in the same cycle.
  - Push and pop in the same cycle on an empty FIFO: the word is pushed; there is no bypass, so it becomes valid next cycle.
  - Push while full with no pop: the word is dropped, overflow is set and held until the next accepted start, and words_sent can then never reach WIDTH/PACK.
  - The tile still completes because DRAIN exits on words_sent == WIDTH/PACK minus dropped words, so a dropped-word counter is kept.
- Word ordering is strict FIFO; addresses are contiguous from base.

Test Plan:
- Single tile with base=0x0100 and dram_wready=1, bytes 0x00..0x3F on 64 consecutive cycles -> 16 writes to 0x0100..0x010F; first word 0x03020100, last 0x3F3E3D3C; tile_done is a single pulse 2 cycles after the last byte; overflow=0.
- Same stimulus with ofmap_valid every other cycle and dram_wready toggling 1/0 -> identical 16 addr/data pairs in order; wdata/waddr stable across every stall.
- dram_wready=0 for the whole COLLECT phase (64 bytes) -> first 8 words buffered, 8 dropped, overflow=1; after release exactly 8 writes to base..base+7, then tile_done; the next start clears overflow.
- base=0xFFFE -> addresses 0xFFFE, 0xFFFF, 0x0000 ... 0x000D.
- rst_n asserted after 20 bytes -> all outputs 0 immediately (asynchronously), no tile_done; a following start with a full tile behaves as in the first scenario.
- start pulsed during COLLECT with a different base_addr -> ignored; addresses continue from the original base, and exactly one tile_done.
